asrm_mem_ctrl: RTL and testbench

Memory controller between the ASRM CPU system bus and the platform's single-port synchronous RAM, plus a small memory-mapped I/O window. It accepts one CPU bus transaction at a time and holds `cpu_ready` low until the RAM read latency has elapsed. It decodes the top 16 words of the address space into on-chip I/O registers. It sits directly downstream of the CPU's address/RAM interface stage.

---
 rtl/asrm_mem_ctrl_pkg.sv | 21 ++
 rtl/asrm_io_regs.sv | 72 +++++++
 rtl/asrm_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_asrm_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrm_mem_ctrl_pkg.sv
// rtl/asrm_mem_ctrl_pkg.sv - shared FSM encodings and I/O window constants for asrm_mem_ctrl
// Purpose: definitions imported by asrm_mem_ctrl and asrm_io_regs.
//   state_t      : controller FSM states (IDLE, RAM_RD, RESP)
//   io_window    : number of words decoded as I/O at the top of the address space
//   io_gpio_out  : offset of the GPIO output register (read/write)
//   io_gpio_in   : offset of the synchronised GPIO input (read-only)
//   io_cycles    : offset of the cycle counter (read-only, optional)
package asrm_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int         io_window   = 16;
    localparam logic [3:0] io_gpio_out = 4'd0;
    localparam logic [3:0] io_gpio_in  = 4'd1;
    localparam logic [3:0] io_cycles   = 4'd2;

endpackage

// File: rtl/asrm_io_regs.sv
// rtl/asrm_io_regs.sv - memory-mapped I/O register block for asrm_mem_ctrl
// Purpose: GPIO output register, two-flop gpio_in synchroniser, optional
// free-running cycle counter (macro ASRM_CYCLE_COUNTER_EN) and offset read mux.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   wr_en         : write strobe for the addressed offset
//   offset        : I/O window offset (cpu_addr[3:0])
//   wdata         : write data
//   gpio_in       : asynchronous input port
//   gpio_out      : output port register
//   rdata         : combinational read value of the addressed offset
module asrm_io_regs
    import asrm_mem_ctrl_pkg::*;
#(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          offset,
    input  logic [wordsize-1:0] wdata,
    input  logic [wordsize-1:0] gpio_in,
    output logic [wordsize-1:0] gpio_out,
    output logic [wordsize-1:0] rdata
);

    logic [wordsize-1:0] gpio_meta;
    logic [wordsize-1:0] gpio_sync;
    logic [wordsize-1:0] cycle_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (wr_en && offset == io_gpio_out) begin
                gpio_out <= wdata;
            end
        end
    end

`ifdef ASRM_CYCLE_COUNTER_EN
    logic [wordsize-1:0] cycles;

    // Counts every clock out of reset and wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 1'b1;
        end
    end

    assign cycle_val = cycles;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            io_gpio_out: rdata = gpio_out;
            io_gpio_in:  rdata = gpio_sync;
            io_cycles:   rdata = cycle_val;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/asrm_mem_ctrl.sv
// rtl/asrm_mem_ctrl.sv - CPU bus to single-port synchronous RAM controller with I/O window
// Purpose: accepts one CPU transaction at a time, decodes the top 16 words to
// asrm_io_regs, drives the RAM strobes and waits out the RAM read latency.
// Optional feature macro: ASRM_CYCLE_COUNTER_EN (cycle counter at I/O offset 2).
// Ports:
//   clk, reset                       : clock, synchronous active-low reset
//   cpu_req/addr/wdata/we            : CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready             : read data, one-cycle completion pulse
//   ram_en/we/addr/wdata, ram_rdata  : RAM interface
//   gpio_in, gpio_out                : GPIO ports
module asrm_mem_ctrl
    import asrm_mem_ctrl_pkg::*;
#(
    parameter int wordsize    = 16,
    parameter int ram_latency = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_we,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_ready,
    output logic                ram_en,
    output logic                ram_we,
    output logic [wordsize-1:0] ram_addr,
    output logic [wordsize-1:0] ram_wdata,
    input  logic [wordsize-1:0] ram_rdata,
    input  logic [wordsize-1:0] gpio_in,
    output logic [wordsize-1:0] gpio_out
);

    localparam logic [3:0] lat_load = 4'(ram_latency - 1);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          lat_cnt;
    logic                io_sel;
    logic                accept;
    logic                io_wr;
    logic [wordsize-1:0] io_rdata;

    // Address >= 2^wordsize - 16 is exactly "all bits above the offset set".
    assign io_sel = &cpu_addr[wordsize-1:4];

    // While cpu_ready is high the FSM is already back in IDLE but the CPU is
    // still holding the finished request; it must not be taken a second time.
    assign accept = reset && (state_q == ST_IDLE) && cpu_req && !cpu_ready;
    assign io_wr  = accept && io_sel && cpu_we;

    asrm_io_regs #(
        .wordsize (wordsize)
    ) u_io_regs (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (io_wr),
        .offset   (cpu_addr[3:0]),
        .wdata    (cpu_wdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .rdata    (io_rdata)
    );

    // RAM strobes are issued in the accepting cycle so the RAM samples the
    // request on the same edge the FSM leaves IDLE.
    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!io_sel) begin
                        ram_en    = 1'b1;
                        ram_we    = cpu_we;
                        ram_addr  = cpu_addr;
                        ram_wdata = cpu_we ? cpu_wdata : '0;
                    end
                    state_d = (io_sel || cpu_we) ? ST_RESP : ST_RAM_RD;
                end
            end
            ST_RAM_RD: begin
                if (lat_cnt == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lat_cnt   <= 4'd0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_ready <= (state_q == ST_RESP);
            if (accept && !io_sel && !cpu_we) begin
                lat_cnt <= lat_load;
            end else if (state_q == ST_RAM_RD && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (state_q == ST_RAM_RD && lat_cnt == 4'd0) begin
                cpu_rdata <= ram_rdata;
            end else if (accept && io_sel && !cpu_we) begin
                cpu_rdata <= io_rdata;
            end
        end
    end

endmodule

// File: tb/tb_asrm_mem_ctrl.sv
// tb/tb_asrm_mem_ctrl.sv - self-checking bench for asrm_mem_ctrl
module tb_asrm_mem_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    asrm_mem_ctrl #(
        .wordsize    (16),
        .ram_latency (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    // Behavioural synchronous RAM: read data appears LAT cycles after the strobe
    // and is poisoned otherwise, so a mistimed capture is visible.
    logic [15:0] ram_arr [0:255];
    logic [15:0] pipe [0:LAT-1];
    int en_cnt = 0;
    int we_cnt = 0;
    int ready_cnt = 0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cpu_ready) ready_cnt <= ready_cnt + 1;
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                we_cnt <= we_cnt + 1;
                ram_arr[ram_addr[7:0]] <= ram_wdata;
            end
        end
        pipe[0] <= (ram_en && !ram_we) ? ram_arr[ram_addr[7:0]] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[LAT-1];

    // Reference model: what the CPU should observe.
    logic [15:0] model_mem [int];
    logic [15:0] model_gpio = 16'h0;
    logic [15:0] model_gin  = 16'h0;
    logic [15:0] model_cnt  = 16'h0;
    bit          in_txn     = 1'b0;

    always @(posedge clk) model_cnt <= reset ? model_cnt + 16'd1 : 16'd0;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a >= 16'hFFF0) begin
            case (a - 16'hFFF0)
                16'd0: return model_gpio;
                16'd1: return model_gin;
`ifdef ASRM_CYCLE_COUNTER_EN
                16'd2: return model_cnt;
`endif
                default: return 16'h0;
            endcase
        end
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare, just after each active edge.
    always @(posedge clk) begin
        #1;
        check("gpio_out", gpio_out, model_gpio);
        if (!in_txn) check("no_stray_ready", cpu_ready, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One CPU transaction, started at a negedge. Returns read data, latency and request cycle.
    task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] wd, input bit drop,
                       output logic [15:0] rd, output int lat, output int req_cyc);
        bit          is_io;
        int          exp_lat;
        logic [15:0] exp_rd;
        int          e0;
        int          w0;
        bit          got;
        is_io   = (a >= 16'hFFF0);
        exp_lat = (is_io || we) ? 2 : LAT + 2;
        exp_rd  = model_read(a);
        e0      = en_cnt;
        w0      = we_cnt;
        req_cyc = cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        in_txn  = 1'b1;
        #1;
        if (!is_io) begin
            check("ram_en_strobe", ram_en, 1'b1);
            check("ram_we_strobe", ram_we, we);
            check("ram_addr", ram_addr, a);
            if (we) check("ram_wdata", ram_wdata, wd);
        end
        if (we) begin
            if (!is_io) model_mem[int'(a)] = wd;
            else if (a == 16'hFFF0) model_gpio = wd;
        end
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            tick();
            lat++;
            if (drop && lat == 1) begin
                cpu_req = 1'b0;
                cpu_addr = 16'hBEEF;
            end
            if (cpu_ready) got = 1'b1;
        end
        check("ready_latency", lat, exp_lat);
        rd = cpu_rdata;
        if (!we) check("rdata", rd, exp_rd);
        check("ram_en_count", en_cnt - e0, is_io ? 0 : 1);
        check("ram_we_count", we_cnt - w0, (!is_io && we) ? 1 : 0);
        cpu_req = 1'b0;
        tick();
        check("ready_pulse_width", cpu_ready, 1'b0);
        if (!we) check("rdata_hold", cpu_rdata, rd);
        in_txn = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] rd1;
        int lat;
        int rc1;
        int rc2;
        int r0;

        reset = 1'b0; cpu_req = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        cpu_we = 1'b0; gpio_in = 16'h0;
        repeat (3) tick();
        reset = 1'b1;

        // Idle after reset: everything zero, no RAM strobes.
        repeat (5) begin
            tick();
            check("rst_ready", cpu_ready, 1'b0);
            check("rst_ram_en", ram_en, 1'b0);
            check("rst_ram_we", ram_we, 1'b0);
            check("rst_ram_addr", ram_addr, 16'h0);
            check("rst_ram_wdata", ram_wdata, 16'h0);
            check("rst_rdata", cpu_rdata, 16'h0);
        end
        check("rst_no_ram_access", en_cnt, 0);

        // RAM write then read back.
        txn(1'b1, 16'h0010, 16'h1234, 1'b0, rd, lat, rc1);
        check("lit_wr_latency", lat, 2);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_rd_data", rd, 16'h1234);
        check("lit_rd_latency", lat, 5);

        // GPIO out and synchronised GPIO in.
        txn(1'b1, 16'hFFF0, 16'hA5A5, 1'b0, rd, lat, rc1);
        check("lit_gpio_out", gpio_out, 16'hA5A5);
        gpio_in = 16'h00FF;
        model_gin = 16'h00FF;
        repeat (3) tick();
        txn(1'b0, 16'hFFF1, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_gpio_in", rd, 16'h00FF);
        txn(1'b0, 16'hFFF0, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_gpio_out_rd", rd, 16'hA5A5);

        // Cycle counter, two reads 10 cycles apart.
        txn(1'b0, 16'hFFF2, 16'h0000, 1'b0, rd1, lat, rc1);
        while (cyc < rc1 + 10) tick();
        txn(1'b0, 16'hFFF2, 16'h0000, 1'b0, rd, lat, rc2);
        check("req_spacing", rc2 - rc1, 10);
`ifdef ASRM_CYCLE_COUNTER_EN
        check("lit_cycles_delta", rd - rd1, 16'd10);
`else
        check("lit_cycles_off_1", rd1, 16'h0);
        check("lit_cycles_off_2", rd, 16'h0);
`endif

        // Request dropped one cycle after issue still completes.
        r0 = ready_cnt;
        txn(1'b0, 16'h0010, 16'h0000, 1'b1, rd, lat, rc1);
        check("lit_drop_data", rd, 16'h1234);
        check("drop_ready_pulses", ready_cnt - r0, 1);

        // Reset during RAM_RD abandons the read.
        txn(1'b1, 16'h0020, 16'h5A5A, 1'b0, rd, lat, rc1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        in_txn = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        model_gpio = 16'h0;
        tick();
        reset = 1'b1;
        in_txn = 1'b0;
        r0 = ready_cnt;
        repeat (6) tick();
        check("abort_no_ready", ready_cnt - r0, 0);
        check("abort_rdata_cleared", cpu_rdata, 16'h0);
        check("abort_gpio_cleared", gpio_out, 16'h0);
        txn(1'b0, 16'h0020, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_after_abort", rd, 16'h5A5A);

        // Top-of-space wrap and read-only / unmapped offsets.
        txn(1'b0, 16'hFFFF, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_ffff_reads_zero", rd, 16'h0);
        txn(1'b1, 16'hFFF1, 16'hFFFF, 1'b0, rd, lat, rc1);
        txn(1'b0, 16'hFFF1, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_gpio_in_ro", rd, 16'h00FF);
        txn(1'b1, 16'hFFF5, 16'h1111, 1'b0, rd, lat, rc1);
        txn(1'b0, 16'hFFF5, 16'h0000, 1'b0, rd, lat, rc1);
        check("lit_unmapped_zero", rd, 16'h0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
